// File: rtl/tone_player.sv
// tone_player: plays one note at a time as a square wave on a speaker pin.
//
// A note is accepted from an upstream sequencer with a valid/ready handshake.
// It plays for note_beats beats (0 encodes 16). Then a silent articulation gap
// follows before the next note can be accepted.
//
// Optional feature: define TONE_PLAYER_DUTY_EN to add the duty[1:0] input. With
// it, the high time becomes period >> duty (50/25/12.5/6.25%), with a minimum of
// one cycle for a nonzero period.
//
// Parameters:
//   CYCLES_PER_BEAT  clk cycles per beat (1..2^32-1)
//   GAP_CYCLES       silent cycles after each note (0..2^32-1)
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   note_valid   upstream presents a note
//   note_ready   block accepts a note this cycle (IDLE and not in reset)
//   note_period  half-period in clk cycles, 0 = rest
//   note_beats   duration in beats, 0 = 16
//   duty         (TONE_PLAYER_DUTY_EN only) duty-cycle select
//   speaker      registered square-wave drive
//   busy         high whenever not IDLE
//   beat_tick    one-cycle pulse on the last PLAY cycle of each beat
module tone_player #(
  parameter int unsigned CYCLES_PER_BEAT = 32'd31250000,
  parameter int unsigned GAP_CYCLES      = 32'd500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        note_valid,
  output logic        note_ready,
  input  logic [19:0] note_period,
  input  logic [3:0]  note_beats,
`ifdef TONE_PLAYER_DUTY_EN
  input  logic [1:0]  duty,
`endif
  output logic        speaker,
  output logic        busy,
  output logic        beat_tick
);

  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

  state_e      state_q;
  logic [19:0] period_q;
  logic [4:0]  beats_q;      // beats remaining, including the current one
  logic [20:0] phase_q;
  logic [31:0] beat_cnt_q;
  logic [31:0] gap_cnt_q;
  logic        speaker_q;
  logic        beat_tick_q;
`ifdef TONE_PLAYER_DUTY_EN
  logic [1:0]  duty_q;
`endif

  logic        accept;
  logic [19:0] in_high_len;  // high length of the note being offered
  logic [19:0] cur_high_len; // high length of the note being played
  logic        last_beat_cycle;
  logic        note_done;
  logic        gap_done;
  logic [31:0] beat_cnt_nxt;
  logic [20:0] phase_wrap;
  logic [20:0] phase_nxt;

  // Reset gates ready so the handshake is dead while rst_n is held low.
  assign note_ready = (state_q == StIdle) && rst_n;
  assign busy       = (state_q != StIdle);
  assign speaker    = speaker_q;
  assign beat_tick  = beat_tick_q;
  assign accept     = note_valid && note_ready;

  always_comb begin
    in_high_len  = note_period;
    cur_high_len = period_q;
`ifdef TONE_PLAYER_DUTY_EN
    in_high_len  = note_period >> duty;
    cur_high_len = period_q >> duty_q;
    if (note_period != 20'd0 && in_high_len == 20'd0) in_high_len = 20'd1;
    if (period_q != 20'd0 && cur_high_len == 20'd0) cur_high_len = 20'd1;
`endif
  end

  always_comb begin
    last_beat_cycle = (beat_cnt_q == 32'(CYCLES_PER_BEAT - 32'd1));
    beat_cnt_nxt    = last_beat_cycle ? 32'd0 : beat_cnt_q + 32'd1;
    note_done       = last_beat_cycle && (beats_q == 5'd1);
    gap_done        = (gap_cnt_q == 32'(GAP_CYCLES - 32'd1));
    phase_wrap      = {period_q, 1'b0} - 21'd1;
    // A rest keeps the phase parked at zero; the speaker stays low regardless.
    phase_nxt       = (period_q == 20'd0 || phase_q == phase_wrap) ? 21'd0 : phase_q + 21'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      period_q    <= 20'd0;
      beats_q     <= 5'd0;
      phase_q     <= 21'd0;
      beat_cnt_q  <= 32'd0;
      gap_cnt_q   <= 32'd0;
      speaker_q   <= 1'b0;
      beat_tick_q <= 1'b0;
`ifdef TONE_PLAYER_DUTY_EN
      duty_q      <= 2'd0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q     <= StPlay;
            period_q    <= note_period;
            beats_q     <= (note_beats == 4'd0) ? 5'd16 : {1'b0, note_beats};
`ifdef TONE_PLAYER_DUTY_EN
            duty_q      <= duty;
`endif
            phase_q     <= 21'd0;
            beat_cnt_q  <= 32'd0;
            // Outputs are registered, so the first PLAY cycle is decided here.
            speaker_q   <= (in_high_len != 20'd0);
            beat_tick_q <= (CYCLES_PER_BEAT == 32'd1);
          end
        end
        StPlay: begin
          if (note_done) begin
            state_q     <= (GAP_CYCLES == 32'd0) ? StIdle : StGap;
            beats_q     <= 5'd0;
            phase_q     <= 21'd0;
            beat_cnt_q  <= 32'd0;
            gap_cnt_q   <= 32'd0;
            speaker_q   <= 1'b0;
            beat_tick_q <= 1'b0;
          end else begin
            phase_q     <= phase_nxt;
            beat_cnt_q  <= beat_cnt_nxt;
            speaker_q   <= (phase_nxt < {1'b0, cur_high_len});
            beat_tick_q <= (beat_cnt_nxt == 32'(CYCLES_PER_BEAT - 32'd1));
            if (last_beat_cycle) beats_q <= beats_q - 5'd1;
          end
        end
        StGap: begin
          if (gap_done) begin
            state_q   <= StIdle;
            gap_cnt_q <= 32'd0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 32'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/tone_player.md
TONE_PLAYER -- requirements
Module: tone_player

Interface
REQ-001 Parameter CYCLES_PER_BEAT, default 31250000, clk cycles per beat (96 bpm at 50 MHz); legal range 1..2^32-1.
REQ-002 Parameter GAP_CYCLES, default 500000, silent articulation gap after each note; legal range 0..2^32-1.
REQ-003 clk  input  1  50 MHz system clock; single clock domain.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 note_valid  input  1  upstream sequencer presents a note.
REQ-006 note_ready  output  1  block can accept a note this cycle.
REQ-007 note_period  input  20  half-period in clk cycles, as produced by freqCalc; 0 = rest.
REQ-008 note_beats  input  4  duration in beats; 0 encodes 16.
REQ-009 speaker  output  1  registered square-wave drive.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 beat_tick  output  1  one-cycle pulse on the last PLAY cycle of each beat.

Function
REQ-012 The FSM shall have exactly three states, IDLE, PLAY and GAP.
REQ-013 note_ready shall equal (state == IDLE).
REQ-014 A note shall be accepted on a rising edge where note_valid && note_ready; period, beats and duty (if enabled) are latched on that edge.
REQ-015 Transitions: IDLE->PLAY on accept; PLAY->GAP after beats*CYCLES_PER_BEAT PLAY cycles; PLAY->IDLE at that point instead if GAP_CYCLES == 0; GAP->IDLE after GAP_CYCLES GAP cycles.
REQ-016 The phase counter (21 bits) shall be 0 in the first PLAY cycle and increment each PLAY cycle, wrapping from 2*period-1 to 0.
REQ-017 speaker (registered) shall be high while phase < high_len and low otherwise; the first high cycle is the cycle after acceptance.
REQ-018 With a 50% duty cycle, high_len shall equal period; period 1 shall toggle speaker every cycle.
REQ-019 A rest (period 0) shall hold speaker low for the full note duration while beat timing proceeds normally.
REQ-020 speaker shall be low in IDLE and GAP.
REQ-021 The beat counter (32 bits) shall count 0..CYCLES_PER_BEAT-1 during PLAY; beat_tick fires when it equals CYCLES_PER_BEAT-1, and the beats-remaining count decrements at that point.
REQ-022 note_valid shall be ignored outside IDLE; latched values shall not change during PLAY or GAP.
REQ-023 A note accepted in IDLE exactly one cycle after leaving GAP shall start with no extra delay (back-to-back throughput: duration + gap + 1 cycle).

Reset
REQ-024 On rst_n low, the block shall enter IDLE asynchronously with speaker=0, beat_tick=0, busy=0, note_ready=0 while rst_n is low, and all counters and latches zeroed.
REQ-025 Reset mid-PLAY or mid-GAP shall abort the note; after release the block shall be IDLE and ready on the first clk edge.

Configuration
REQ-026 Macro TONE_PLAYER_DUTY_EN: when defined, the block shall add input duty[1:0] (latched on accept) and set high_len = period >> duty (50/25/12.5/6.25%), clamped to a minimum of 1 when period is nonzero.
REQ-027 Without TONE_PLAYER_DUTY_EN, the duty port shall be absent and high_len shall equal period.

Verification (bench: CYCLES_PER_BEAT=100, GAP_CYCLES=10)
REQ-028 Accept period=5, beats=2 -> speaker high 5/low 5 for exactly 200 cycles; beat_tick at PLAY cycles 100 and 200; then 10 low GAP cycles; note_ready returns on the 211th cycle after accept.
REQ-029 Accept period=0, beats=1 -> speaker low throughout, one beat_tick, busy high for 110 cycles.
REQ-030 Accept beats=0, period=1 -> speaker toggles every cycle for 1600 cycles with 16 beat_ticks.
REQ-031 Hold note_valid high with a changed period during PLAY -> no effect on the current note; the new note is accepted only on return to IDLE.
REQ-032 Assert rst_n=0 at PLAY cycle 50 -> speaker, busy and beat_tick are 0 without waiting for a clk edge; after release, note_ready=1.
REQ-033 With TONE_PLAYER_DUTY_EN, period=8, duty=2 -> speaker high 2 / low 14 per cycle; with period=2, duty=3 -> high 1 / low 3 (clamp case).
